// File: rtl/dcache_wt_ctrl_if.sv
// CPU-side and RAM-side handshake bundle for the write-through data cache.
// The master view belongs to whoever drives requests and plays the RAM; the slave view belongs to the cache.
interface dcache_wt_ctrl_if;
    logic        cpu_req;
    logic        cpu_rw;
    logic [9:0]  cpu_addr;
    logic [9:0]  cpu_wdata;
    logic [9:0]  cpu_rdata;
    logic        cache_ready;
    logic        mem_req;
    logic        mem_rw;
    logic [9:0]  mem_addr;
    logic [19:0] mem_wdata;
    logic [19:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output cpu_req, cpu_rw, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
        input  cpu_rdata, cache_ready, mem_req, mem_rw, mem_addr, mem_wdata
    );

    modport slave (
        input  cpu_req, cpu_rw, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
        output cpu_rdata, cache_ready, mem_req, mem_rw, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_wt_ctrl.sv
// Direct-mapped, write-through, write-allocate cache between the 10-bit CPU and the 20-bit line RAM.
// Each line holds two words; misses fill the whole line, and stores are written through as whole lines.
module dcache_wt_ctrl #(
    parameter int INDEX_W = 3,
    parameter int SAT_MAX = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    dcache_wt_ctrl_if.slave    bus,
    output logic [7:0]         hit_count_o,
    output logic [7:0]         miss_count_o
);
    localparam int          LINES   = 1 << INDEX_W;
    localparam int          TAG_W   = 9 - INDEX_W;
    localparam logic [7:0]  SAT_VAL = 8'(SAT_MAX);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_e;

    state_e             state_q, state_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [19:0]        data_q [LINES];
    logic [7:0]         hitCnt_q, hitCnt_d, missCnt_q, missCnt_d;
    logic               replay_q, replay_d;
    logic               memReq_q, memReq_d, memRw_q, memRw_d;
    logic [9:0]         memAddr_q, memAddr_d;
    logic [19:0]        memWdata_q, memWdata_d;

    logic [INDEX_W-1:0] cpuIdx, fillIdx, lineIdx;
    logic [TAG_W-1:0]   cpuTag, fillTag;
    logic [19:0]        curLine, mergedLine, lineData;
    logic [9:0]         cpuWord, cpuRdata;
    logic               cpuHit, lineWe, tagWe, cacheReady;

    assign cpuIdx     = bus.cpu_addr[INDEX_W:1];
    assign cpuTag     = bus.cpu_addr[9:INDEX_W+1];
    assign fillIdx    = memAddr_q[INDEX_W:1];
    assign fillTag    = memAddr_q[9:INDEX_W+1];
    assign curLine    = data_q[cpuIdx];
    assign cpuHit     = valid_q[cpuIdx] && (tag_q[cpuIdx] == cpuTag);
    assign cpuWord    = bus.cpu_addr[0] ? curLine[19:10] : curLine[9:0];
    assign mergedLine = bus.cpu_addr[0] ? {bus.cpu_wdata, curLine[9:0]}
                                        : {curLine[19:10], bus.cpu_wdata};

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        hitCnt_d   = hitCnt_q;
        missCnt_d  = missCnt_q;
        replay_d   = replay_q;
        memReq_d   = memReq_q;
        memRw_d    = memRw_q;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        cacheReady = 1'b0;
        cpuRdata   = '0;
        lineWe     = 1'b0;
        tagWe      = 1'b0;
        lineIdx    = cpuIdx;
        lineData   = mergedLine;

        unique case (state_q)
            IDLE: begin
                if (!bus.cpu_req) begin
                    cacheReady = 1'b1;
                end else if (cpuHit) begin
                    // A hit that follows our own fill is the replayed access, already counted as a miss.
                    replay_d = 1'b0;
                    if (!replay_q && hitCnt_q != SAT_VAL) hitCnt_d = hitCnt_q + 8'd1;
                    if (!bus.cpu_rw) begin
                        cacheReady = 1'b1;
                        cpuRdata   = cpuWord;
                    end else begin
                        lineWe     = 1'b1;
                        memWdata_d = mergedLine;
                        memAddr_d  = {bus.cpu_addr[9:1], 1'b0};
                        memReq_d   = 1'b1;
                        memRw_d    = 1'b1;
                        state_d    = WRITE;
                    end
                end else begin
                    if (missCnt_q != SAT_VAL) missCnt_d = missCnt_q + 8'd1;
                    memAddr_d = {bus.cpu_addr[9:1], 1'b0};
                    memReq_d  = 1'b1;
                    memRw_d   = 1'b0;
                    state_d   = FILL;
                end
            end
            FILL: begin
                if (bus.mem_ready) begin
                    lineWe           = 1'b1;
                    tagWe            = 1'b1;
                    lineIdx          = fillIdx;
                    lineData         = bus.mem_rdata;
                    valid_d[fillIdx] = 1'b1;
                    replay_d         = 1'b1;
                    memReq_d         = 1'b0;
                    state_d          = IDLE;
                end
            end
            WRITE: begin
                if (bus.mem_ready) begin
                    memReq_d = 1'b0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                cacheReady = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            hitCnt_q   <= '0;
            missCnt_q  <= '0;
            replay_q   <= 1'b0;
            memReq_q   <= 1'b0;
            memRw_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            hitCnt_q   <= hitCnt_d;
            missCnt_q  <= missCnt_d;
            replay_q   <= replay_d;
            memReq_q   <= memReq_d;
            memRw_q    <= memRw_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
        end
    end

    // Line payload and tags are qualified by the valid bits, so they need no reset.
    always_ff @(posedge clk) begin
        if (lineWe) data_q[lineIdx] <= lineData;
        if (tagWe)  tag_q[lineIdx]  <= fillTag;
    end

    assign bus.cache_ready = cacheReady | ~rst_n;
    assign bus.cpu_rdata   = cpuRdata;
    assign bus.mem_req     = memReq_q;
    assign bus.mem_rw      = memRw_q;
    assign bus.mem_addr    = memAddr_q;
    assign bus.mem_wdata   = memWdata_q;
    assign hit_count_o     = hitCnt_q;
    assign miss_count_o    = missCnt_q;
endmodule
